// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the transmitter: the frame state
// encoding, the CSR field positions and the data-bit count clamp.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT
  } uart_state_e;

  localparam int CSR_NBITS_LSB = 0;
  localparam int CSR_NBITS_MSB = 3;
  localparam int CSR_STOP2     = 4;
  localparam int CSR_PAR_EN    = 5;
  localparam int CSR_PAR_ODD   = 6;

  // Only 5..8 data bits are meaningful; anything else falls back to 8.
  function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
    return (n >= 4'd5 && n <= 4'd8) ? n : 4'd8;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset to the
// idle-high line level.
module uart_rx_sync (
  input  logic tick,
  input  logic rst,
  input  logic rx_in,
  output logic rxs
);

  logic meta_q, rxs_q;

  always_ff @(posedge tick or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rx_in;
      rxs_q  <= meta_q;
    end
  end

  assign rxs = rxs_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled deframing with parity and framing checks. Data bits
// are packed LSB-first into WORD_W-bit words, which are pushed to the RX FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS    = 16,
  parameter int WORD_W = 32
) (
  input  logic              tick,
  input  logic              rst,
  input  logic [31:0]       csr,
  input  logic              rx_in,
  input  logic              fifo_full,
  input  logic              err_clr,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err
);

  localparam int CW  = $clog2(OVS);
  localparam int WBW = $clog2(WORD_W + 1);
  localparam int IW  = $clog2(WORD_W);
  localparam logic [CW-1:0]  HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0]  LAST = CW'(OVS - 1);
  localparam logic [WBW-1:0] FULL = WBW'(WORD_W);

  logic rxs;

  uart_rx_sync u_sync (
    .tick  (tick),
    .rst   (rst),
    .rx_in (rx_in),
    .rxs   (rxs)
  );

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        bitn_q, bitn_d;
  logic [WBW-1:0]    wbits_q, wbits_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              par_q, par_d;
  logic [6:0]        shadow_q, shadow_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;

  logic       sample, wchk, perr_set, ferr_set, oerr_set;
  logic [3:0] nbits;
  logic       unused_csr;

  assign unused_csr = ^csr[31:7];
  assign sample     = (cnt_q == LAST);
  assign nbits      = clamp_nbits(shadow_q[CSR_NBITS_MSB:CSR_NBITS_LSB]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitn_d   = bitn_q;
    wbits_d  = wbits_q;
    word_d   = word_q;
    par_d    = par_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    wchk     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    oerr_set = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        // Counter restarts at the start-bit midpoint, so every later sample
        // lands at LAST, one full bit period apart.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d  = DATA;
            shadow_d = csr[6:0];
            bitn_d   = '0;
            par_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          par_d  = par_q ^ rxs;
          bitn_d = bitn_q + 1'b1;
          if (wbits_q != FULL) begin
            word_d[wbits_q[IW-1:0]] = rxs;
            wbits_d                 = wbits_q + 1'b1;
          end
          if (bitn_q == nbits - 4'd1)
            state_d = shadow_q[CSR_PAR_EN] ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (sample) begin
          if ((par_q ^ rxs) != shadow_q[CSR_PAR_ODD]) perr_set = 1'b1;
          state_d = STOP1;
        end
      end
      STOP1, STOP2: begin
        if (sample) begin
          if (!rxs) begin
            ferr_set = 1'b1;
            wbits_d  = '0;
            state_d  = BREAK_WAIT;
          end else if (state_q == STOP1 && shadow_q[CSR_STOP2]) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            wchk    = 1'b1;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wchk && wbits_q == FULL) begin
      wbits_d = '0;
      if (!fifo_full) begin
        data_d  = word_q;
        valid_d = 1'b1;
      end else begin
        oerr_set = 1'b1;
      end
    end

    perr_d = (perr_q & ~err_clr) | perr_set;
    ferr_d = (ferr_q & ~err_clr) | ferr_set;
    oerr_d = (oerr_q & ~err_clr) | oerr_set;
  end

  always_ff @(posedge tick or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitn_q   <= '0;
      wbits_q  <= '0;
      word_q   <= '0;
      par_q    <= 1'b0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitn_q   <= bitn_d;
      wbits_q  <= wbits_d;
      word_q   <= word_d;
      par_q    <= par_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      oerr_q   <= oerr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != IDLE);
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected words are queued as frames are sent, and a
// monitor pops and compares on every rx_valid strobe.
module tb_uart_rx;

  localparam int OVS = 16;

  logic        tick = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] csr = '0;
  logic        rx_in = 1'b1;
  logic        fifo_full = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] rx_data;
  logic        rx_valid, rx_busy, parity_err, frame_err, overrun_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 tick = ~tick;

  uart_rx #(.OVS(OVS), .WORD_W(32)) dut (
    .tick        (tick),
    .rst         (rst),
    .csr         (csr),
    .rx_in       (rx_in),
    .fifo_full   (fifo_full),
    .err_clr     (err_clr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge tick) begin
    if (rst && rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got %h, expected no push", rx_data);
      end else begin
        chk("push_data", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic drive_bit(input logic v);
    @(negedge tick);
    rx_in = v;
    repeat (OVS - 1) @(negedge tick);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit par_en,
                            input bit par_val, input bit stop_val, input int nstop);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_val);
    drive_bit(stop_val);
    for (int i = 1; i < nstop; i++) drive_bit(1'b1);
  endtask

  task automatic send8(input logic [7:0] d);
    send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1);
  endtask

  task automatic settle();
    repeat (4) @(negedge tick);
  endtask

  task automatic clr_err();
    @(negedge tick) err_clr = 1'b1;
    @(negedge tick) err_clr = 1'b0;
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, parity_err, frame_err, overrun_err};
  endfunction

  initial begin
    @(negedge tick);
    chk("rst_data",  rx_data, 32'h0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy",  rx_busy, 0);
    chk("rst_flags", flags(), 0);
    rst = 1'b1;
    repeat (5) @(negedge tick);

    // Four 8-bit frames assemble one word, LSB byte first.
    csr = 32'h08;
    exp_q.push_back(32'h12345678);
    send8(8'h78); send8(8'h56); send8(8'h34); send8(8'h12);
    settle();
    chk("t1_pushed", exp_q.size(), 0);
    chk("t1_flags",  flags(), 0);

    // Odd parity: 0xA5 has four ones, so the correct parity bit is 1.
    csr = 32'h68;
    exp_q.push_back(32'hA5A5A5A5);
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1);
    settle();
    chk("t2_perr_good", parity_err, 0);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1);
    settle();
    chk("t2_perr_bad", parity_err, 1);
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1);
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1);
    settle();
    chk("t2_pushed", exp_q.size(), 0);
    chk("t2_other_flags", {frame_err, overrun_err}, 0);
    clr_err();
    chk("t2_clr", flags(), 0);

    // Framing error followed by a long break.
    csr = 32'h08;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1);
    repeat (2 * OVS) @(negedge tick);
    chk("t3_ferr", frame_err, 1);
    chk("t3_busy_break", rx_busy, 1);
    clr_err();
    repeat (38 * OVS) @(negedge tick);
    chk("t3_single_ferr", frame_err, 0);
    @(negedge tick) rx_in = 1'b1;
    repeat (2 * OVS) @(negedge tick);
    chk("t3_idle", rx_busy, 0);
    exp_q.push_back(32'hEFBEADDE);
    send8(8'hDE); send8(8'hAD); send8(8'hBE); send8(8'hEF);
    settle();
    chk("t3_pushed", exp_q.size(), 0);

    // False start between frames must not disturb the partial word.
    exp_q.push_back(32'h04030201);
    send8(8'h01); send8(8'h02);
    @(negedge tick) rx_in = 1'b0;
    repeat (4) @(negedge tick);
    rx_in = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge tick);
        if (rx_busy) seen = 1'b1;
      end
      chk("t4_busy_pulse", seen, 1);
    end
    repeat (20) @(negedge tick);
    chk("t4_idle", rx_busy, 0);
    chk("t4_flags", flags(), 0);
    send8(8'h03); send8(8'h04);
    settle();
    chk("t4_pushed", exp_q.size(), 0);

    // Overrun: FIFO full when the word completes.
    send8(8'h11); send8(8'h22); send8(8'h33);
    fifo_full = 1'b1;
    send8(8'h44);
    settle();
    chk("t5_oerr", overrun_err, 1);
    chk("t5_data_hold", rx_data, 32'h04030201);
    fifo_full = 1'b0;
    clr_err();
    chk("t5_clr", overrun_err, 0);

    // Reset in the middle of a frame; even parity with a wrong bit sets a flag first.
    csr = 32'h28;
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1, 1);
    settle();
    chk("t6_perr", parity_err, 1);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    @(negedge tick) rst = 1'b0;
    #1;
    chk("t6_rst_data",  rx_data, 32'h0);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_busy",  rx_busy, 0);
    chk("t6_rst_flags", flags(), 0);
    rx_in = 1'b1;
    repeat (3) @(negedge tick);
    rst = 1'b1;
    repeat (4) @(negedge tick);
    csr = 32'h0C;  // out-of-range bit count falls back to 8
    exp_q.push_back(32'h89ABCDEF);
    send8(8'hEF); send8(8'hCD); send8(8'hAB); send8(8'h89);
    settle();
    chk("t6_pushed", exp_q.size(), 0);

    // 5-bit frames, two stop bits: 35 bits arrive, the last 3 are dropped.
    csr = 32'h15;
    exp_q.push_back(32'hCC520C41);
    send_frame(8'h01, 5, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h02, 5, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h03, 5, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h04, 5, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h05, 5, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h06, 5, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 2);
    settle();
    chk("t7_pushed", exp_q.size(), 0);
    chk("t7_flags",  flags(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
